multicycle_controller: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It decodes the instruction-register opcode and sequences one instruction over 3–5 cycles. It drives every datapath mux and enable, plus the 2-bit `alu_ctrl` class code consumed by `alu_controller`, which turns that code and `func` into the 3-bit ALU operation. It sits between the instruction register and the datapath, and handshakes with instruction/data memory through `mem_ready`.

---
 rtl/multicycle_controller_pkg.sv | 108 ++++++++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 139 +++++++++++++
 tb/tb_multicycle_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU/func codes,
// control-bus encodings, FSM states and the opcode-class helper.
package multicycle_controller_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNC_W     = 6;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned ALU_CTRL_W = 2;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned CLS_W      = 3;

  // ALU operation codes produced by alu_controller
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] FUNC_AND = 6'h24;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 6'h25;
  localparam logic [FUNC_W-1:0] FUNC_SLT = 6'h2a;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_MTYPE = 2'b00,
    ALU_BTYPE = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_JTYPE = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_LW_READ  = 4'd4,
    ST_LW_WB    = 4'd5,
    ST_SW_WRITE = 4'd6,
    ST_R_EX     = 4'd7,
    ST_R_WB     = 4'd8,
    ST_I_EX     = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BEQ      = 4'd11,
    ST_JMP      = 4'd12
  } state_e;

  // Opcode class latched in DECODE; CLS_NONE doubles as the reset value
  typedef enum logic [CLS_W-1:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5,
    CLS_ADDI = 3'd6
  } op_cls_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    pc_src_e    pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_ctrl_e  alu_ctrl;
    logic       illegal_op;
  } ctrl_t;

  function automatic op_cls_e decode_class(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE: return CLS_R;
      OP_LW:    return CLS_LW;
      OP_SW:    return CLS_SW;
      OP_BEQ:   return CLS_BEQ;
      OP_J:     return CLS_J;
      OP_ADDI:  return CLS_ADDI;
      default:  return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the instruction register/memory side and the datapath.
// The controller is the master; the datapath (or bench) is the slave.
interface multicycle_controller_if;
  import multicycle_controller_pkg::*;

  logic [OPCODE_W-1:0]   opcode;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  pc_write_cond;
  logic [1:0]            pc_src;
  logic                  i_or_d;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  illegal_op;
  logic [STATE_W-1:0]    state_dbg;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_ctrl, illegal_op, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_ctrl, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences one instruction over
// 3-5 cycles (plus memory wait states) and decodes every datapath control from state.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master ctl
);

  state_e  state_q, state_d;
  op_cls_e cls_q, cls_d;
  ctrl_t   ctl_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next state; the opcode class is captured only in DECODE
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (ctl.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = decode_class(ctl.opcode);
        case (cls_d)
          CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
          CLS_R:          state_d = ST_R_EX;
          CLS_ADDI:       state_d = ST_I_EX;
          CLS_BEQ:        state_d = ST_BEQ;
          CLS_J:          state_d = ST_JMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: state_d = (cls_q == CLS_LW) ? ST_LW_READ : ST_SW_WRITE;
      ST_LW_READ:  if (ctl.mem_ready) state_d = ST_LW_WB;
      ST_LW_WB:    state_d = ST_FETCH;
      ST_SW_WRITE: if (ctl.mem_ready) state_d = ST_FETCH;
      ST_R_EX:     state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_I_EX:     state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_BEQ:      state_d = ST_FETCH;
      ST_JMP:      state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Moore output decode; only FETCH write enables and DECODE illegal_op see inputs
  always_comb begin
    ctl_c          = '0;
    ctl_c.alu_ctrl = ALU_JTYPE;
    case (state_q)
      ST_IDLE: ctl_c.alu_ctrl = ALU_MTYPE;
      ST_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.alu_ctrl  = ALU_MTYPE;
        ctl_c.pc_src    = PCSRC_ALU;
        ctl_c.ir_write  = ctl.mem_ready;
        ctl_c.pc_write  = ctl.mem_ready;
      end
      ST_DECODE: begin
        ctl_c.alu_src_b  = SRCB_IMM_SH;
        ctl_c.alu_ctrl   = ALU_MTYPE;
        ctl_c.illegal_op = (decode_class(ctl.opcode) == CLS_NONE);
      end
      ST_MEM_ADDR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_ctrl  = ALU_MTYPE;
      end
      ST_LW_READ: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.i_or_d   = 1'b1;
      end
      ST_LW_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 1'b1;
      end
      ST_SW_WRITE: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.i_or_d    = 1'b1;
      end
      ST_R_EX: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_B;
        ctl_c.alu_ctrl  = ALU_RTYPE;
      end
      ST_R_WB: begin
        ctl_c.reg_write = 1'b1;
        ctl_c.reg_dst   = 1'b1;
      end
      ST_I_EX: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_ctrl  = ALU_MTYPE;
      end
      ST_I_WB: ctl_c.reg_write = 1'b1;
      ST_BEQ: begin
        ctl_c.alu_src_a     = 1'b1;
        ctl_c.alu_src_b     = SRCB_B;
        ctl_c.alu_ctrl      = ALU_BTYPE;
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_src        = PCSRC_ALUOUT;
      end
      ST_JMP: begin
        ctl_c.pc_write = 1'b1;
        ctl_c.pc_src   = PCSRC_JUMP;
      end
      default: ctl_c.alu_ctrl = ALU_MTYPE;
    endcase
  end

  assign ctl.pc_write      = ctl_c.pc_write;
  assign ctl.pc_write_cond = ctl_c.pc_write_cond;
  assign ctl.pc_src        = ctl_c.pc_src;
  assign ctl.i_or_d        = ctl_c.i_or_d;
  assign ctl.mem_read      = ctl_c.mem_read;
  assign ctl.mem_write     = ctl_c.mem_write;
  assign ctl.ir_write      = ctl_c.ir_write;
  assign ctl.reg_dst       = ctl_c.reg_dst;
  assign ctl.mem_to_reg    = ctl_c.mem_to_reg;
  assign ctl.reg_write     = ctl_c.reg_write;
  assign ctl.alu_src_a     = ctl_c.alu_src_a;
  assign ctl.alu_src_b     = ctl_c.alu_src_b;
  assign ctl.alu_ctrl      = ctl_c.alu_ctrl;
  assign ctl.illegal_op    = ctl_c.illegal_op;
  assign ctl.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected state/output sequences
// built from the instruction rules, checked every cycle on the falling edge.
`timescale 1ns/1ps
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if dif();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (dif.master)
  );

  int          checks = 0;
  int          failures = 0;
  logic [20:0] exp_v;
  logic        exp_valid = 1'b0;
  string       exp_name;
  int          n_ir, n_mw, n_ill;

  // Field order: pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
  // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
  // illegal_op, state
  function automatic logic [20:0] act_vec();
    return {dif.pc_write, dif.pc_write_cond, dif.pc_src, dif.i_or_d, dif.mem_read,
            dif.mem_write, dif.ir_write, dif.reg_dst, dif.mem_to_reg, dif.reg_write,
            dif.alu_src_a, dif.alu_src_b, dif.alu_ctrl, dif.illegal_op, dif.state_dbg};
  endfunction

  function automatic logic [20:0] exp_vec(input state_e st, input logic mr,
                                          input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill;
    logic [1:0] pcs, srcb, alu;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0;
    m2r = 0; rw = 0; srca = 0; ill = 0; pcs = 2'b00; srcb = 2'b00; alu = 2'b11;
    case (st)
      ST_IDLE:     alu = 2'b00;
      ST_FETCH:    begin mrd = 1; srcb = 2'b01; alu = 2'b00; irw = mr; pcw = mr; end
      ST_DECODE: begin
        srcb = 2'b11; alu = 2'b00;
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      end
      ST_MEM_ADDR: begin srca = 1; srcb = 2'b10; alu = 2'b00; end
      ST_LW_READ:  begin mrd = 1; iord = 1; end
      ST_LW_WB:    begin rw = 1; m2r = 1; end
      ST_SW_WRITE: begin mwr = 1; iord = 1; end
      ST_R_EX:     begin srca = 1; srcb = 2'b00; alu = 2'b10; end
      ST_R_WB:     begin rw = 1; rdst = 1; end
      ST_I_EX:     begin srca = 1; srcb = 2'b10; alu = 2'b00; end
      ST_I_WB:     rw = 1;
      ST_BEQ:      begin srca = 1; alu = 2'b01; pcwc = 1; pcs = 2'b01; end
      ST_JMP:      begin pcw = 1; pcs = 2'b10; end
      default:     alu = 2'b00;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, alu, ill, 4'(st)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  // Called at posedge+1: drive one cycle, arm the expectation, tally pulses
  task automatic step(input state_e st, input logic mr, input logic [5:0] op,
                      input string tname);
    dif.mem_ready = mr;
    dif.opcode    = op;
    exp_v         = exp_vec(st, mr, op);
    exp_name      = {tname, "/", st.name()};
    exp_valid     = 1'b1;
    @(negedge clk); #1;
    n_ir  += int'(dif.ir_write);
    n_mw  += int'(dif.mem_write);
    n_ill += int'(dif.illegal_op);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int exp_cycles, input string tname);
    state_e     seq[$];
    logic       mrs[$];
    logic [5:0] other;
    int         extra;
    other = (op == 6'b100011) ? 6'b101011 : 6'b100011;
    n_ir = 0; n_mw = 0; n_ill = 0;
    for (int i = 0; i < fw; i++) begin seq.push_back(ST_FETCH); mrs.push_back(1'b0); end
    seq.push_back(ST_FETCH);  mrs.push_back(1'b1);
    seq.push_back(ST_DECODE); mrs.push_back(1'b0);
    case (op)
      6'b100011: begin
        seq.push_back(ST_MEM_ADDR); mrs.push_back(1'b0);
        for (int i = 0; i < mw; i++) begin seq.push_back(ST_LW_READ); mrs.push_back(1'b0); end
        seq.push_back(ST_LW_READ); mrs.push_back(1'b1);
        seq.push_back(ST_LW_WB);   mrs.push_back(1'b0);
      end
      6'b101011: begin
        seq.push_back(ST_MEM_ADDR); mrs.push_back(1'b0);
        for (int i = 0; i < mw; i++) begin seq.push_back(ST_SW_WRITE); mrs.push_back(1'b0); end
        seq.push_back(ST_SW_WRITE); mrs.push_back(1'b1);
      end
      6'b000000: begin seq.push_back(ST_R_EX); mrs.push_back(1'b1);
                       seq.push_back(ST_R_WB); mrs.push_back(1'b0); end
      6'b001000: begin seq.push_back(ST_I_EX); mrs.push_back(1'b0);
                       seq.push_back(ST_I_WB); mrs.push_back(1'b1); end
      6'b000100: begin seq.push_back(ST_BEQ); mrs.push_back(1'b0); end
      6'b000010: begin seq.push_back(ST_JMP); mrs.push_back(1'b1); end
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++)
      step(seq[i], mrs[i], (seq[i] == ST_DECODE) ? op : other, tname);
    exp_valid = 1'b0;
    extra = 0;
    while (dif.state_dbg != 4'(ST_FETCH) && extra < 20) begin
      @(posedge clk); #1;
      extra++;
    end
    check({tname, "_cycles"}, 32'(seq.size() + extra), 32'(exp_cycles));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (exp_valid) begin
          checks++;
          if (act_vec() !== exp_v) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", exp_name, act_vec(), exp_v);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
      end
    join_none

    rst_n = 1'b0; dif.opcode = 6'b0; dif.mem_ready = 1'b0;
    exp_v = exp_vec(ST_IDLE, 1'b0, 6'b0); exp_name = "reset/IDLE"; exp_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; dif.mem_ready = ~dif.mem_ready; end
    rst_n = 1'b1; exp_name = "reset_release/IDLE";
    @(posedge clk); #1;

    run_instr(6'b100011, 0, 0, 5, "lw");
    run_instr(6'b000000, 0, 0, 4, "rtype");
    run_instr(6'b000100, 0, 0, 3, "beq");
    run_instr(6'b000010, 0, 0, 3, "j");
    run_instr(6'b001000, 0, 0, 4, "addi");
    run_instr(6'b101011, 2, 2, 8, "sw_wait");
    check("sw_wait_ir_pulses", 32'(n_ir), 32'd1);
    check("sw_wait_mem_write_cycles", 32'(n_mw), 32'd3);
    run_instr(6'b111111, 0, 0, 2, "illegal");
    check("illegal_pulses", 32'(n_ill), 32'd1);
    run_instr(6'b100011, 1, 1, 7, "lw_wait");
    check("lw_wait_ir_pulses", 32'(n_ir), 32'd1);
    run_instr(6'b101011, 0, 0, 4, "sw");

    // Reset in the middle of LW_READ
    step(ST_FETCH, 1'b1, 6'b101011, "abort");
    step(ST_DECODE, 1'b0, 6'b100011, "abort");
    step(ST_MEM_ADDR, 1'b1, 6'b101011, "abort");
    dif.mem_ready = 1'b0;
    exp_v = exp_vec(ST_LW_READ, 1'b0, 6'b0); exp_name = "abort/LW_READ";
    @(negedge clk); #1;
    exp_valid = 1'b0;
    rst_n = 1'b0;
    dif.mem_ready = 1'b1;
    #1;
    check("rst_abort_outputs", 32'(act_vec()), 32'(exp_vec(ST_IDLE, 1'b1, 6'b0)));
    exp_v = exp_vec(ST_IDLE, 1'b1, 6'b0); exp_name = "abort_reset/IDLE"; exp_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1; exp_name = "abort_release/IDLE";
    @(posedge clk); #1;
    run_instr(6'b000000, 0, 0, 4, "rtype_after_abort");

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
